// File: rtl/dma_addr_gen_mc_pkg.sv
// am2940_pkg: instruction/mode encodings and control-register bit positions
package am2940_pkg;

    typedef enum logic [2:0] {
        WR_CR   = 3'b000,
        RD_CR   = 3'b001,
        RD_WC   = 3'b010,
        RD_AC   = 3'b011,
        REINIT  = 3'b100,
        LD_ADDR = 3'b101,
        LD_WC   = 3'b110,
        ENCT    = 3'b111
    } instr_e;

    typedef enum logic [1:0] {
        COUNT_DOWN   = 2'd0,
        WC_COMPARE   = 2'd1,
        ADDR_COMPARE = 2'd2,
        FREE_RUN     = 2'd3
    } mode_e;

    localparam int CR_DIR  = 2;
    localparam int CR_AUTO = 3;

endpackage

// File: rtl/dma_addr_gen_mc_channel.sv
// dma_channel: one channel's registers, counters, terminal/done logic and carry outputs
module dma_channel
    import am2940_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_cr,
    input  logic             i_reinit,
    input  logic             i_ld_addr,
    input  logic             i_ld_wc,
    input  logic             i_enct,
    input  logic             i_aci,
    input  logic             i_wci,
    input  logic [WIDTH-1:0] i_data,
    output logic [3:0]       o_cr,
    output logic [WIDTH-1:0] o_ac,
    output logic [WIDTH-1:0] o_wc,
    output logic             o_done,
    output logic             o_aco,
    output logic             o_wco
);

    logic [3:0]       r_cr;
    logic [WIDTH-1:0] r_ar, r_wr, r_ac, r_wc;
    logic             r_done;

    mode_e            w_mode;
    logic             w_dir, w_auto, w_wcc, w_term, w_go, w_reload, w_clr;
    logic [WIDTH-1:0] w_next_ac, w_next_wc;

    assign w_mode    = mode_e'(r_cr[1:0]);
    assign w_dir     = r_cr[CR_DIR];
    assign w_auto    = r_cr[CR_AUTO];
    assign w_wcc     = w_mode == WC_COMPARE;
    assign w_next_ac = w_dir ? r_ac - 1'b1 : r_ac + 1'b1;
    assign w_next_wc = w_mode == COUNT_DOWN ? r_wc - 1'b1 : r_wc + 1'b1;

    // Terminal test looks at pre-step values; the word-count register doubles as end address
    assign w_term = i_wci && (w_mode == COUNT_DOWN   ? r_wc == WIDTH'(1) :
                              w_mode == WC_COMPARE   ? w_next_wc == r_wr :
                              w_mode == ADDR_COMPARE ? i_aci && w_next_ac == r_wr :
                                                       1'b0);
    assign w_go     = i_enct && (!r_done || w_auto);
    assign w_reload = i_reinit || (w_go && w_term && w_auto);
    assign w_clr    = i_wr_cr || i_reinit || i_ld_addr || i_ld_wc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cr   <= '0;
            r_ar   <= '0;
            r_wr   <= '0;
            r_ac   <= '0;
            r_wc   <= '0;
            r_done <= 1'b0;
        end else begin
            if (i_wr_cr) r_cr <= i_data[3:0];
            if (i_ld_addr) r_ar <= i_data;
            if (i_ld_wc) r_wr <= i_data;
            r_ac   <= i_ld_addr ? i_data : w_reload ? r_ar : (w_go && i_aci) ? w_next_ac : r_ac;
            r_wc   <= i_ld_wc ? (w_wcc ? '0 : i_data) : w_reload ? (w_wcc ? '0 : r_wr) :
                      (w_go && i_wci) ? w_next_wc : r_wc;
            r_done <= w_clr ? 1'b0 : (w_go && w_term) ? 1'b1 : r_done;
        end
    end

    assign o_cr   = r_cr;
    assign o_ac   = r_ac;
    assign o_wc   = r_wc;
    assign o_done = r_done;
    assign o_aco  = i_aci && r_ac == {WIDTH{!w_dir}};
    assign o_wco  = i_wci && r_wc == {WIDTH{w_mode != COUNT_DOWN}};

endmodule

// File: rtl/dma_addr_gen_mc.sv
// dma_addr_gen_mc: multi-channel DMA address generator; decodes the shared instruction
// bus, muxes the selected channel onto the outputs and holds the read-back register.
module dma_addr_gen_mc
    import am2940_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CHW   = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       instr,
    input  logic [CHW-1:0]   ch_sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic             oe_n,
    output logic [WIDTH-1:0] address,
    input  logic             aci,
    output logic             aco,
    input  logic             wci,
    output logic             wco,
    output logic             done,
    output logic [NCH-1:0]   done_vec
);

    instr_e                      w_instr;
    logic [NCH-1:0]              w_sel, w_aco, w_wco;
    logic [NCH-1:0][3:0]         w_cr;
    logic [NCH-1:0][WIDTH-1:0]   w_ac, w_wc;
    logic                        w_valid, w_done_sel, w_aco_sel, w_wco_sel;
    logic [3:0]                  w_cr_sel;
    logic [WIDTH-1:0]            w_ac_sel, w_wc_sel;
    logic [WIDTH-1:0]            r_data_out;

    assign w_instr = instr_e'(instr);
    assign w_valid = |w_sel;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_sel[g] = ch_sel == CHW'(g);
        dma_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_wr_cr  (w_sel[g] && w_instr == WR_CR),
            .i_reinit (w_sel[g] && w_instr == REINIT),
            .i_ld_addr(w_sel[g] && w_instr == LD_ADDR),
            .i_ld_wc  (w_sel[g] && w_instr == LD_WC),
            .i_enct   (w_sel[g] && w_instr == ENCT),
            .i_aci    (aci),
            .i_wci    (wci),
            .i_data   (data_in),
            .o_cr     (w_cr[g]),
            .o_ac     (w_ac[g]),
            .o_wc     (w_wc[g]),
            .o_done   (done_vec[g]),
            .o_aco    (w_aco[g]),
            .o_wco    (w_wco[g])
        );
    end

    // AND-OR mux: an out-of-range ch_sel selects nothing and yields zeros
    always_comb begin
        w_cr_sel   = '0;
        w_ac_sel   = '0;
        w_wc_sel   = '0;
        w_done_sel = 1'b0;
        w_aco_sel  = 1'b0;
        w_wco_sel  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_cr_sel   = w_cr_sel | ({4{w_sel[i]}} & w_cr[i]);
            w_ac_sel   = w_ac_sel | ({WIDTH{w_sel[i]}} & w_ac[i]);
            w_wc_sel   = w_wc_sel | ({WIDTH{w_sel[i]}} & w_wc[i]);
            w_done_sel = w_done_sel | (w_sel[i] & done_vec[i]);
            w_aco_sel  = w_aco_sel | (w_sel[i] & w_aco[i]);
            w_wco_sel  = w_wco_sel | (w_sel[i] & w_wco[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_data_out <= '0;
        else if (w_valid && (w_instr == RD_CR || w_instr == RD_WC || w_instr == RD_AC))
            r_data_out <= w_instr == RD_CR ? WIDTH'(w_cr_sel) : w_instr == RD_WC ? w_wc_sel : w_ac_sel;
    end

    assign data_out = r_data_out;
    assign address  = oe_n ? '0 : w_ac_sel;
    assign aco      = w_aco_sel;
    assign wco      = w_wco_sel;
    assign done     = w_done_sel;

endmodule

// File: tb/tb_dma_addr_gen_mc.sv
// tb_dma_addr_gen_mc: scoreboard bench; a behavioural channel model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_dma_addr_gen_mc;
    import am2940_pkg::*;

    localparam int W = 8, N = 3, M = 256, MSK = 255;

    logic           clk = 1'b0, rst;
    logic [2:0]     instr;
    logic [1:0]     ch_sel;
    logic [W-1:0]   data_in, data_out, address;
    logic           oe_n, aci, aco, wci, wco, done;
    logic [N-1:0]   done_vec;

    dma_addr_gen_mc #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .rst(rst), .instr(instr), .ch_sel(ch_sel), .data_in(data_in),
        .data_out(data_out), .oe_n(oe_n), .address(address), .aci(aci), .aco(aco),
        .wci(wci), .wco(wco), .done(done), .done_vec(done_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int addr, aco, wco, done, dv, dout;
    } exp_t;

    exp_t  q[$];
    exp_t  me;
    int    n_chk = 0, n_pass = 0;
    int    m_cr[N], m_ar[N], m_wr[N], m_ac[N], m_wc[N], m_done[N], m_dout;
    string tag = "init";

    task automatic cmp(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int dv_model();
        int v = 0;
        for (int i = 0; i < N; i++) v |= m_done[i] << i;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cr[i] = 0; m_ar[i] = 0; m_wr[i] = 0; m_ac[i] = 0; m_wc[i] = 0; m_done[i] = 0;
        end
        m_dout = 0;
    endfunction

    // Reference behaviour of one instruction on one channel, in plain modular arithmetic
    function automatic void apply(input int in, input int ch, input int d, input bit a, input bit w);
        int mode, na;
        bit dir, au, term;
        if (ch >= N) return;
        mode = m_cr[ch] & 3;
        dir  = 1'((m_cr[ch] >> 2) & 1);
        au   = 1'((m_cr[ch] >> 3) & 1);
        case (in)
            0: begin m_cr[ch] = d & 15; m_done[ch] = 0; end
            1: m_dout = m_cr[ch];
            2: m_dout = m_wc[ch];
            3: m_dout = m_ac[ch];
            4: begin m_ac[ch] = m_ar[ch]; m_wc[ch] = mode == 1 ? 0 : m_wr[ch]; m_done[ch] = 0; end
            5: begin m_ar[ch] = d; m_ac[ch] = d; m_done[ch] = 0; end
            6: begin m_wr[ch] = d; m_wc[ch] = mode == 1 ? 0 : d; m_done[ch] = 0; end
            default: if (!m_done[ch] || au) begin
                na   = (m_ac[ch] + (dir ? M - 1 : 1)) % M;
                term = w && (mode == 0 ? m_wc[ch] == 1 :
                             mode == 1 ? (m_wc[ch] + 1) % M == m_wr[ch] :
                             mode == 2 ? (a && na == m_wr[ch]) : 1'b0);
                if (term) m_done[ch] = 1;
                if (term && au) begin
                    m_ac[ch] = m_ar[ch];
                    m_wc[ch] = mode == 1 ? 0 : m_wr[ch];
                end else begin
                    if (a) m_ac[ch] = na;
                    if (w) m_wc[ch] = (m_wc[ch] + (mode == 0 ? M - 1 : 1)) % M;
                end
            end
        endcase
    endfunction

    // Drive one cycle, predict the outputs the monitor will see before the edge, advance the model
    task automatic step(input logic [2:0] in, input int ch, input int dd, input bit a, input bit w, input bit oe);
        exp_t e;
        int   c, d, mode;
        bit   v, dir;
        d = dd & MSK;
        instr = in; ch_sel = 2'(ch); data_in = 8'(d); aci = a; wci = w; oe_n = oe;
        v    = ch < N;
        c    = v ? ch : 0;
        mode = m_cr[c] & 3;
        dir  = 1'((m_cr[c] >> 2) & 1);
        e.nm   = tag;
        e.addr = (v && !oe) ? m_ac[c] : 0;
        e.aco  = int'(v && a && m_ac[c] == (dir ? 0 : MSK));
        e.wco  = int'(v && w && m_wc[c] == (mode == 0 ? 0 : MSK));
        e.done = int'(v && m_done[c] != 0);
        e.dv   = dv_model();
        e.dout = m_dout;
        q.push_back(e);
        apply(int'(in), ch, d, a, w);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            me = q.pop_front();
            cmp({me.nm, " address"}, int'(address), me.addr);
            cmp({me.nm, " aco"}, int'(aco), me.aco);
            cmp({me.nm, " wco"}, int'(wco), me.wco);
            cmp({me.nm, " done"}, int'(done), me.done);
            cmp({me.nm, " done_vec"}, int'(done_vec), me.dv);
            cmp({me.nm, " data_out"}, int'(data_out), me.dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr = RD_CR; ch_sel = 0; data_in = 0; aci = 0; wci = 0; oe_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset address", int'(address), 0);
        cmp("reset aco", int'(aco), 0);
        cmp("reset wco", int'(wco), 0);
        cmp("reset done", int'(done), 0);
        cmp("reset data_out", int'(data_out), 0);
        rst = 1'b0;

        tag = "t2 count_down";
        step(WR_CR, 0, 'h0, 0, 0, 0);
        step(LD_WC, 0, 3, 0, 0, 0);
        step(LD_ADDR, 0, 'h6C, 0, 0, 0);
        repeat (4) step(ENCT, 0, 0, 1, 1, 0);
        cmp("t2 final address", int'(address), 'h6F);
        cmp("t2 done_vec", int'(done_vec), 1);
        step(RD_WC, 0, 0, 0, 0, 0);
        cmp("t2 rd_wc", int'(data_out), 0);

        tag = "t3 addr_compare";
        step(WR_CR, 1, 'h6, 0, 0, 0);
        step(LD_WC, 1, 'h10, 0, 0, 0);
        step(LD_ADDR, 1, 'h14, 0, 0, 0);
        repeat (3) step(ENCT, 1, 0, 1, 1, 0);
        cmp("t3 done_vec before end", int'(done_vec), 1);
        step(ENCT, 1, 0, 1, 1, 0);
        cmp("t3 end address", int'(address), 'h10);
        cmp("t3 done_vec", int'(done_vec), 3);
        step(RD_AC, 0, 0, 0, 0, 0);
        cmp("t3 ch0 rd_ac", int'(data_out), 'h6F);

        tag = "t4 autoreinit";
        step(WR_CR, 0, 'h8, 0, 0, 0);
        step(LD_WC, 0, 2, 0, 0, 0);
        step(LD_ADDR, 0, 'hFE, 0, 0, 0);
        repeat (4) step(ENCT, 0, 0, 1, 1, 0);
        cmp("t4 address", int'(address), 'hFE);
        cmp("t4 done", int'(done), 1);

        tag = "t5 free_run";
        step(WR_CR, 0, 'h3, 0, 0, 0);
        step(LD_WC, 0, 'hFE, 0, 0, 0);
        repeat (2) step(ENCT, 0, 0, 0, 1, 0);
        repeat (2) step(ENCT, 0, 0, 0, 0, 0);
        step(RD_WC, 0, 0, 0, 0, 0);
        cmp("t5 rd_wc", int'(data_out), 0);
        cmp("t5 done", int'(done), 0);

        tag = "t6 wc_compare";
        step(WR_CR, 0, 'h1, 0, 0, 0);
        step(LD_WC, 0, 2, 0, 0, 0);
        repeat (3) step(ENCT, 0, 0, 1, 1, 0);
        step(RD_WC, 0, 0, 0, 0, 0);
        cmp("t6 rd_wc", int'(data_out), 2);
        cmp("t6 done", int'(done), 1);
        step(REINIT, 0, 0, 0, 0, 0);
        step(RD_WC, 0, 0, 0, 0, 0);
        cmp("t6 rd_wc after reinit", int'(data_out), 0);
        cmp("t6 done after reinit", int'(done), 0);

        tag = "invalid ch";
        step(LD_ADDR, 3, 'h55, 0, 0, 0);
        step(ENCT, 3, 0, 1, 1, 0);
        step(RD_AC, 3, 0, 1, 1, 0);

        tag = "random";
        repeat (400) begin
            int r;
            r = $urandom_range(0, 11);
            step(3'(r > 7 ? 7 : r), $urandom_range(0, 3), int'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        end

        tag = "t1 async reset";
        step(WR_CR, 1, 'h0, 0, 0, 0);
        step(LD_WC, 1, 1, 0, 0, 0);
        step(ENCT, 1, 0, 1, 1, 0);
        step(WR_CR, 0, 'h3, 0, 0, 0);
        step(LD_ADDR, 0, 'h40, 0, 0, 0);
        step(RD_AC, 0, 0, 0, 0, 0);
        step(ENCT, 0, 0, 1, 1, 0);
        step(ENCT, 0, 0, 1, 1, 0);
        rst = 1'b1;
        #2;
        cmp("t1 address in reset", int'(address), 0);
        cmp("t1 data_out in reset", int'(data_out), 0);
        cmp("t1 done_vec in reset", int'(done_vec), 0);
        rst = 1'b0;
        model_reset();
        step(RD_AC, 0, 0, 0, 0, 0);
        cmp("t1 ch0 rd_ac after reset", int'(data_out), 0);
        step(RD_AC, 1, 0, 0, 0, 0);
        step(RD_CR, 1, 0, 0, 0, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) cmp("scoreboard drain", q.size(), 0);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
